// File: rtl/fsk_tx_scheduler.sv
// BFSK transmit sequencer: host byte stream -> modulator start pulse plus MSB-first bit stream.
// Optional 8'hAA preamble between sync and data is enabled by defining FSK_SCHED_PREAMBLE_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for the first byte of a frame
// ST_SYNC     | modulator sync burst, SYNC_LENGTH+2 cycles incl. start cycle
// ST_PREAMBLE | 8'hAA preamble, MSB-first (FSK_SCHED_PREAMBLE_EN only)
// ST_DATA     | serialising sh MSB-first, one bit per SAMPLES_PER_SYMBOL
// ST_GAP      | idle guard gap with mod_data low
module fsk_tx_scheduler #(
    parameter int SAMPLES_PER_SYMBOL = 64,
    parameter int SYNC_LENGTH        = 10,
    parameter int GAP_CYCLES         = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       mod_start,
    output logic       mod_data,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int M1      = (SYNC_LENGTH + 1 > SAMPLES_PER_SYMBOL - 1) ? SYNC_LENGTH + 1
                                                                         : SAMPLES_PER_SYMBOL - 1;
    localparam int CNT_MAX = (M1 > GAP_CYCLES - 1) ? M1 : GAP_CYCLES - 1;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_LENGTH + 1);
    localparam logic [CNT_W-1:0] SYM_LOAD  = CNT_W'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef FSK_SCHED_PREAMBLE_EN
    localparam logic [7:0] PREAMBLE_PAT = 8'hAA;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PREAMBLE,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       sh, sh_nxt;
    logic             sh_last, sh_last_nxt;
    logic [7:0]       nx, nx_nxt;
    logic             nx_last, nx_last_nxt;
    logic             nx_valid, nx_valid_nxt;
    logic             ready_en;
    logic             xfer;
    logic             start_nxt;
    logic             underrun_nxt;
    logic             data_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    // ready_en keeps s_ready low while reset is asserted even though state sits in IDLE
    always_comb begin
        s_ready = 1'b0;
        if (ready_en) begin
            case (state)
                ST_IDLE: s_ready = 1'b1;
                ST_GAP:  s_ready = 1'b0;
                default: s_ready = !nx_valid;
            endcase
        end
    end

    assign xfer = s_valid && s_ready;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        sh_nxt       = sh;
        sh_last_nxt  = sh_last;
        nx_nxt       = nx;
        nx_last_nxt  = nx_last;
        nx_valid_nxt = nx_valid;
        start_nxt    = 1'b0;
        underrun_nxt = 1'b0;

        // mid-frame arrivals fill nx first, so a same-cycle byte boundary already sees them
        if (xfer && state != ST_IDLE) begin
            nx_nxt       = s_data;
            nx_last_nxt  = s_last;
            nx_valid_nxt = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (nx_valid || xfer) begin
                    if (nx_valid) begin
                        sh_nxt       = nx;
                        sh_last_nxt  = nx_last;
                        nx_valid_nxt = xfer;
                        if (xfer) begin
                            nx_nxt      = s_data;
                            nx_last_nxt = s_last;
                        end
                    end else begin
                        sh_nxt      = s_data;
                        sh_last_nxt = s_last;
                    end
                    idx_nxt   = 3'd7;
                    cnt_nxt   = SYNC_LOAD;
                    start_nxt = 1'b1;
                    state_nxt = ST_SYNC;
                end
            end

            ST_SYNC: begin
                if (cnt == '0) begin
                    idx_nxt = 3'd7;
                    cnt_nxt = SYM_LOAD;
`ifdef FSK_SCHED_PREAMBLE_EN
                    state_nxt = ST_PREAMBLE;
`else
                    state_nxt = ST_DATA;
`endif
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

`ifdef FSK_SCHED_PREAMBLE_EN
            ST_PREAMBLE: begin
                if (cnt == '0) begin
                    cnt_nxt = SYM_LOAD;
                    if (idx == 3'd0) begin
                        idx_nxt   = 3'd7;
                        state_nxt = ST_DATA;
                    end else begin
                        idx_nxt = idx - 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
`endif

            ST_DATA: begin
                if (cnt == '0) begin
                    cnt_nxt = SYM_LOAD;
                    if (idx != 3'd0) begin
                        idx_nxt = idx - 3'd1;
                    end else if (sh_last) begin
                        cnt_nxt   = GAP_LOAD;
                        state_nxt = ST_GAP;
                    end else if (nx_valid_nxt) begin
                        sh_nxt       = nx_nxt;
                        sh_last_nxt  = nx_last_nxt;
                        nx_valid_nxt = 1'b0;
                        idx_nxt      = 3'd7;
                    end else begin
                        underrun_nxt = 1'b1;
                        cnt_nxt      = GAP_LOAD;
                        state_nxt    = ST_GAP;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // outputs are registered from next-state values so they line up with the state they describe
    always_comb begin
        data_nxt = 1'b0;
        case (state_nxt)
`ifdef FSK_SCHED_PREAMBLE_EN
            ST_SYNC:     data_nxt = 1'b1;
            ST_PREAMBLE: data_nxt = PREAMBLE_PAT[idx_nxt];
`else
            ST_SYNC:     data_nxt = sh_nxt[7];
`endif
            ST_DATA:     data_nxt = sh_nxt[idx_nxt];
            default:     data_nxt = 1'b0;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_nxt == ST_GAP) && (cnt_nxt == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= 3'd0;
            sh         <= 8'h00;
            sh_last    <= 1'b0;
            nx         <= 8'h00;
            nx_last    <= 1'b0;
            nx_valid   <= 1'b0;
            ready_en   <= 1'b0;
            mod_start  <= 1'b0;
            mod_data   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            sh         <= sh_nxt;
            sh_last    <= sh_last_nxt;
            nx         <= nx_nxt;
            nx_last    <= nx_last_nxt;
            nx_valid   <= nx_valid_nxt;
            ready_en   <= 1'b1;
            mod_start  <= start_nxt;
            mod_data   <= data_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
            underrun   <= underrun_nxt;
        end
    end

endmodule
